// File: rtl/apb_initiator.sv
// APB initiator: valid/ready request channel to a multi-slot APB bus, one transfer outstanding.
// Optional ACCESS-phase timeout abort is enabled by defining APB_INIT_TIMEOUT_EN.
//
// state    | meaning
// S_IDLE   | req_ready high, waiting for a request
// S_SETUP  | PSEL asserted, PENABLE low, one cycle
// S_ACCESS | PENABLE high, waiting on the selected PREADY
// S_RESP   | response presented until rsp_ready
module apb_initiator #(
  parameter  int ADDR_WIDTH     = 12,
  parameter  int SLAVE_BITS     = 2,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int NSLOTS         = 2 ** SLAVE_BITS,
  localparam int PAW            = ADDR_WIDTH - SLAVE_BITS
) (
  input  logic                  clk_cpu,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic [PAW-1:0]        apb_PADDR,
  output logic [NSLOTS-1:0]     apb_PSEL,
  output logic                  apb_PENABLE,
  output logic                  apb_PWRITE,
  output logic [31:0]           apb_PWDATA,
  input  logic [NSLOTS-1:0]     apb_PREADY,
  input  logic [32*NSLOTS-1:0]  apb_PRDATA
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [SLAVE_BITS-1:0] slot_q, slot_d;
  logic [PAW-1:0]        paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic [NSLOTS-1:0]     psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [31:0]           prdata_sel;
  logic                  pready_sel;

`ifdef APB_INIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  assign pready_sel = apb_PREADY[slot_q];

  always_comb begin
    prdata_sel = '0;
    for (int k = 0; k < NSLOTS; k++) begin
      if (slot_q == SLAVE_BITS'(k)) prdata_sel = apb_PRDATA[32*k +: 32];
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
`ifdef APB_INIT_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d  = S_SETUP;
          slot_d   = req_addr[ADDR_WIDTH-1 -: SLAVE_BITS];
          paddr_d  = req_addr[PAW-1:0];
          pwrite_d = req_write;
          pwdata_d = req_wdata;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
`ifdef APB_INIT_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_ACCESS: begin
        if (pready_sel) begin
          state_d     = S_RESP;
          rsp_rdata_d = pwrite_q ? 32'h0 : prdata_sel;
          rsp_error_d = 1'b0;
        end
`ifdef APB_INIT_TIMEOUT_EN
        else begin
          // A ready on the terminal cycle takes the branch above, so completion wins
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            state_d     = S_RESP;
            rsp_rdata_d = 32'h0;
            rsp_error_d = 1'b1;
          end
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state
    req_ready_d = (state_d == S_IDLE);
    psel_d      = (state_d == S_SETUP || state_d == S_ACCESS) ? (NSLOTS'(1) << slot_d) : '0;
    penable_d   = (state_d == S_ACCESS);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state_q     <= S_IDLE;
      slot_q      <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
`ifdef APB_INIT_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
`ifdef APB_INIT_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign apb_PADDR   = paddr_q;
  assign apb_PSEL    = psel_q;
  assign apb_PENABLE = penable_q;
  assign apb_PWRITE  = pwrite_q;
  assign apb_PWDATA  = pwdata_q;

endmodule
